// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue.
// The bundle width and PC width follow the INST_ADDR_WIDTH / FETCH_WIDTH macros
// when the surrounding build provides them; otherwise local defaults are used.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 1
`endif

package fetch_pkg;

  localparam int FQ_DEPTH   = 4;
  localparam int FQ_ADDR_W  = `INST_ADDR_WIDTH;
  localparam int FQ_FW      = `FETCH_WIDTH;
  localparam int FQ_INSTR_W = 32;
  localparam int FQ_CNT_W   = $clog2(FQ_DEPTH + 1);

  // One fetch bundle: FW instructions plus the PC of instruction 0.
  typedef struct packed {
    logic [FQ_FW-1:0][FQ_INSTR_W-1:0] instr;
    logic [FQ_ADDR_W-1:0]             pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_queue_ptr_ctrl.sv
// Pointer / occupancy control for the fetch queue.
// Owns read and write pointers, the occupancy count, full/empty decode and the
// qualification of push and pop. Flush outranks everything; reset clears all.
module fq_ptr_ctrl
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic             deq_ready,
  input  logic             bypass,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             push,
  output logic             pop
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Advance a pointer by one entry, wrapping from DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Status decode from registered count plus handshake qualification.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    push  = enq_valid & ~full & ~bypass & ~flush;
    pop   = ~empty & deq_ready & ~flush;
  end

  // Next-state for pointers and occupancy; flush returns everything to zero.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Register pointers and count with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: bundle buffer between the IFU and decode.
// Holds up to DEPTH fetch bundles in a circular buffer, stalls the IFU when full
// and drops everything on flush.
// Build options:
//   FETCH_Q_BYPASS_EN  - an empty queue hands a bundle straight to decode in the
//                        same cycle when decode is ready (the bundle is not stored).
//   FETCH_Q_DROP_CHECK - simulation-only $error when the IFU presents a bundle
//                        while the queue is full (the bundle is dropped).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH  = FQ_DEPTH,
  parameter  int ADDR_W = FQ_ADDR_W,
  parameter  int FW     = FQ_FW,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq_valid,
  input  logic [FW-1:0][31:0]   enq_instr,
  input  logic [ADDR_W-1:0]     enq_pc,
  output logic                  stall,
  input  logic                  flush,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [FW-1:0][31:0]   deq_instr,
  output logic [ADDR_W-1:0]     deq_pc,
  output logic [CNT_W-1:0]      count
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bypass;

  fetch_bundle_t    mem_q [DEPTH];
  fetch_bundle_t    mem_d [DEPTH];
  fetch_bundle_t    wr_bundle;
  fetch_bundle_t    head;

`ifdef FETCH_Q_BYPASS_EN
  assign bypass = empty & enq_valid & deq_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  fq_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .deq_ready (deq_ready),
    .bypass    (bypass),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .push      (push),
    .pop       (pop)
  );

  // Storage next-state: write the incoming bundle at the tail on an accepted push.
  always_comb begin
    wr_bundle.instr = enq_instr;
    wr_bundle.pc    = enq_pc;
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr] = wr_bundle;
    end
  end

  // Bundle storage; contents are don't-care while unoccupied, so no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head output mux, zeroed when nothing is presented to decode.
  always_comb begin
    head      = mem_q[rd_ptr];
    deq_valid = ~empty;
    deq_instr = '0;
    deq_pc    = '0;
    if (!empty) begin
      deq_instr = head.instr;
      deq_pc    = head.pc;
    end
`ifdef FETCH_Q_BYPASS_EN
    else if (bypass) begin
      deq_valid = 1'b1;
      deq_instr = enq_instr;
      deq_pc    = enq_pc;
    end
`endif
  end

  assign stall = full;

`ifdef FETCH_Q_DROP_CHECK
  // Flag bundles the IFU sends while the queue is already full.
  always_ff @(posedge clk) begin
    if (!reset && !flush && enq_valid && full) begin
      $error("fetch_queue: bundle pc=%0h dropped while full", enq_pc);
    end
  end
`endif

  // Pop is consumed inside the pointer controller; keep it visible for debug.
  logic unused_pop;
  assign unused_pop = pop;

endmodule
